// File: rtl/reaction_meter_core.sv
// Reaction-time meter: random pre-stimulus delay, ms reaction count, Avalon-MM
// register access and a level interrupt to the CPU.
module reaction_meter_core #(
  parameter logic [15:0] MIN_DELAY_MS = 16'd1000,
  parameter logic [15:0] DELAY_MASK   = 16'h07FF,
  parameter logic [15:0] TIMEOUT_MS   = 16'd9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_ms,
  input  logic        button_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        stimulus_led
);

  typedef enum logic [1:0] {IDLE, DELAY, STIM} state_t;

  state_t      state, state_nx;
  logic [15:0] delay_cnt, delay_nx;
  logic [15:0] ms_cnt, ms_nx;
  logic [15:0] result, result_nx;
  logic [15:0] lfsr, lfsr_nx;
  logic [15:0] rd_nx;
  logic        done, done_nx;
  logic        early, early_nx;
  logic        timeout, timeout_nx;
  logic        ien, ien_nx;
  logic        btn_q;
  logic        wr, wr_status, wr_ctrl, wr_lfsr;
  logic        start, abort, press;

  assign wr        = chipselect & ~write_n;
  assign wr_status = wr & (address == 2'd0);
  assign wr_ctrl   = wr & (address == 2'd1);
  assign wr_lfsr   = wr & (address == 2'd3);
  // Abort outranks start when both bits are written together.
  assign abort     = wr_ctrl & writedata[2];
  assign start     = wr_ctrl & writedata[1] & ~writedata[2];
  assign press     = btn_q & ~button_n;

  assign irq = ien & (done | early | timeout);

  always_comb begin
    state_nx   = state;
    delay_nx   = delay_cnt;
    ms_nx      = ms_cnt;
    result_nx  = result;
    ien_nx     = wr_ctrl ? writedata[0] : ien;
    // Clear first so any flag set below in the same cycle wins.
    done_nx    = done & ~wr_status;
    early_nx   = early & ~wr_status;
    timeout_nx = timeout & ~wr_status;
    lfsr_nx    = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};
    if (wr_lfsr) lfsr_nx = (writedata == '0) ? LFSR_SEED : writedata;

    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = DELAY;
          delay_nx   = MIN_DELAY_MS + (lfsr & DELAY_MASK);
          done_nx    = 1'b0;
          early_nx   = 1'b0;
          timeout_nx = 1'b0;
        end
      end
      DELAY: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (press) begin
          early_nx = 1'b1;
          state_nx = IDLE;
        end else if (tick_ms) begin
          if (delay_cnt <= 16'd1) begin
            state_nx = STIM;
            ms_nx    = '0;
          end else begin
            delay_nx = delay_cnt - 16'd1;
          end
        end
      end
      STIM: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (press) begin
          result_nx = ms_cnt;
          done_nx   = 1'b1;
          state_nx  = IDLE;
        end else if (tick_ms) begin
          if (ms_cnt == TIMEOUT_MS - 16'd1) begin
            result_nx  = TIMEOUT_MS;
            timeout_nx = 1'b1;
            state_nx   = IDLE;
          end else begin
            ms_nx = ms_cnt + 16'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_nx = '0;
    case (address)
      2'd0: rd_nx = {12'b0, timeout, early, (state != IDLE), done};
      2'd1: rd_nx = {15'b0, ien};
      2'd2: rd_nx = result;
      2'd3: rd_nx = lfsr;
      default: rd_nx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      delay_cnt    <= '0;
      ms_cnt       <= '0;
      result       <= '0;
      lfsr         <= LFSR_SEED;
      done         <= 1'b0;
      early        <= 1'b0;
      timeout      <= 1'b0;
      ien          <= 1'b0;
      btn_q        <= 1'b1;
      readdata     <= '0;
      stimulus_led <= 1'b0;
    end else begin
      state        <= state_nx;
      delay_cnt    <= delay_nx;
      ms_cnt       <= ms_nx;
      result       <= result_nx;
      lfsr         <= lfsr_nx;
      done         <= done_nx;
      early        <= early_nx;
      timeout      <= timeout_nx;
      ien          <= ien_nx;
      btn_q        <= button_n;
      readdata     <= rd_nx;
      stimulus_led <= (state_nx == STIM);
    end
  end

endmodule
